// File: rtl/rvvi_pkg.sv
// Shared types for the RVVI host/DUT link: sync state, frame classification
// and the default frame-count tag width used on both sides of the link.
package rvvi_pkg;

  localparam int RVVI_FRAME_COUNT_WIDTH = 16;

  typedef enum logic {
    STATE_UNSYNCED,
    STATE_SYNCED
  } rvvi_state_e;

  typedef enum logic [1:0] {
    CLASS_NONE,
    CLASS_STORE,
    CLASS_DUP,
    CLASS_DROP
  } rvvi_class_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rvvi_reorder_slots.sv
// Reorder window storage: one frame, tag and valid bit per slot, with a
// single write port, a single clear port and combinational reads at the
// head slot and at the slot addressed by the incoming frame.
module rvvi_reorder_slots
  import rvvi_pkg::*;
#(
  parameter int Entries           = 3,
  parameter int WIDTH             = 792,
  parameter int FRAME_COUNT_WIDTH = RVVI_FRAME_COUNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [Entries-1:0]           wr_idx,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [FRAME_COUNT_WIDTH-1:0] wr_tag,
  input  logic                         clr_en,
  input  logic [Entries-1:0]           clr_idx,
  input  logic [Entries-1:0]           lookup_idx,
  output logic                         lookup_valid,
  output logic [FRAME_COUNT_WIDTH-1:0] lookup_tag,
  input  logic [Entries-1:0]           head_idx,
  output logic                         head_valid,
  output logic [FRAME_COUNT_WIDTH-1:0] head_tag,
  output logic [WIDTH-1:0]             head_data,
  output logic                         any_valid
);

  localparam int SLOTS = 1 << Entries;

  logic [WIDTH-1:0]             data_q [SLOTS];
  logic [WIDTH-1:0]             data_d [SLOTS];
  logic [FRAME_COUNT_WIDTH-1:0] tag_q  [SLOTS];
  logic [FRAME_COUNT_WIDTH-1:0] tag_d  [SLOTS];
  logic [SLOTS-1:0]             valid_q;
  logic [SLOTS-1:0]             valid_d;

  // Valid bits: drain clears the head slot, a stored frame sets its slot
  always_comb begin
    valid_d = valid_q;
    if (clr_en) begin
      valid_d[clr_idx] = 1'b0;
    end
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Payload and tag are only written when a new frame is stored
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (wr_en) begin
      data_d[wr_idx] = wr_data;
      tag_d[wr_idx]  = wr_tag;
    end
  end

  // Valid bits are the only storage that needs a reset value
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload/tag storage is qualified by the valid bits, so it is not reset
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign lookup_valid = valid_q[lookup_idx];
  assign lookup_tag   = tag_q[lookup_idx];
  assign head_valid   = valid_q[head_idx];
  assign head_tag     = tag_q[head_idx];
  assign head_data    = data_q[head_idx];
  assign any_valid    = |valid_q;

endmodule

// File: rtl/rvvi_host_reorder_receiver.sv
// Host-side RVVI reorder receiver: classifies incoming tagged frames against
// the next expected frame count, buffers in-window frames, delivers them in
// tag order over valid/ready, acks accepted and replayed frames, and flags a
// head-of-line gap that persists too long.
module rvvi_host_reorder_receiver
  import rvvi_pkg::*;
#(
  parameter int Entries           = 3,
  parameter int WIDTH             = 792,
  parameter int FRAME_COUNT_WIDTH = RVVI_FRAME_COUNT_WIDTH,
  parameter int GAP_TIMEOUT       = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RxValid,
  input  logic [WIDTH-1:0]             RxData,
  output logic                         OutValid,
  output logic [WIDTH-1:0]             OutData,
  input  logic                         OutReady,
  output logic                         AckValid,
  output logic [FRAME_COUNT_WIDTH-1:0] AckFrameCount,
  output logic [FRAME_COUNT_WIDTH-1:0] ExpectedCount,
  output logic                         GapDetected,
  output logic [15:0]                  DropCount,
  output logic [15:0]                  DupCount
);

  localparam int SLOTS = 1 << Entries;
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [FRAME_COUNT_WIDTH-1:0] WINDOW    = FRAME_COUNT_WIDTH'(SLOTS);
  localparam logic [GAP_W-1:0]             GAP_LIMIT = GAP_W'(GAP_TIMEOUT);

  rvvi_state_e                  state_q, state_d;
  logic [FRAME_COUNT_WIDTH-1:0] expected_q, expected_d;
  logic                         ack_valid_q, ack_valid_d;
  logic [FRAME_COUNT_WIDTH-1:0] ack_count_q, ack_count_d;
  logic [15:0]                  drop_q, drop_d;
  logic [15:0]                  dup_q, dup_d;
  logic [GAP_W-1:0]             gap_timer_q, gap_timer_d;

  logic                         synced;
  logic                         load_expected;
  logic [FRAME_COUNT_WIDTH-1:0] rx_tag;
  logic [Entries-1:0]           rx_idx;
  logic [Entries-1:0]           head_idx;
  logic [FRAME_COUNT_WIDTH-1:0] class_base;
  logic [FRAME_COUNT_WIDTH-1:0] rx_diff;
  rvvi_class_e                  rx_class;
  logic                         lookup_valid;
  logic [FRAME_COUNT_WIDTH-1:0] lookup_tag;
  logic                         head_valid;
  logic [FRAME_COUNT_WIDTH-1:0] head_tag;
  logic [WIDTH-1:0]             head_data;
  logic                         any_valid;
  logic                         out_fire;

  assign rx_tag   = RxData[FRAME_COUNT_WIDTH-1:0];
  assign rx_idx   = rx_tag[Entries-1:0];
  assign head_idx = expected_q[Entries-1:0];

  rvvi_reorder_slots #(
    .Entries           (Entries),
    .WIDTH             (WIDTH),
    .FRAME_COUNT_WIDTH (FRAME_COUNT_WIDTH)
  ) u_slots (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (rx_class == CLASS_STORE),
    .wr_idx       (rx_idx),
    .wr_data      (RxData),
    .wr_tag       (rx_tag),
    .clr_en       (out_fire),
    .clr_idx      (head_idx),
    .lookup_idx   (rx_idx),
    .lookup_valid (lookup_valid),
    .lookup_tag   (lookup_tag),
    .head_idx     (head_idx),
    .head_valid   (head_valid),
    .head_tag     (head_tag),
    .head_data    (head_data),
    .any_valid    (any_valid)
  );

  // Sync state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_UNSYNCED;
    end else begin
      state_q <= state_d;
    end
  end

  // The first received frame locks the receiver; only reset unlocks it
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_UNSYNCED: if (RxValid) state_d = STATE_SYNCED;
      STATE_SYNCED:   state_d = STATE_SYNCED;
      default:        state_d = STATE_UNSYNCED;
    endcase
  end

  // Per-state controls: load the tag base while unsynced, run the gap timer once synced
  always_comb begin
    synced        = 1'b0;
    load_expected = 1'b0;
    case (state_q)
      STATE_UNSYNCED: load_expected = RxValid;
      STATE_SYNCED:   synced        = 1'b1;
      default:        ;
    endcase
  end

  // Classify the incoming frame against the pre-drain expected count
  always_comb begin
    class_base = load_expected ? rx_tag : expected_q;
    rx_diff    = rx_tag - class_base;
    rx_class   = CLASS_NONE;
    if (RxValid) begin
      if (rx_diff < WINDOW) begin
        if (!lookup_valid) begin
          rx_class = CLASS_STORE;
        end else if (lookup_tag == rx_tag) begin
          rx_class = CLASS_DUP;
        end else begin
          rx_class = CLASS_DROP;
        end
      end else if (rx_diff[FRAME_COUNT_WIDTH-1]) begin
        rx_class = CLASS_DUP;
      end else begin
        rx_class = CLASS_DROP;
      end
    end
  end

  assign OutValid = head_valid && (head_tag == expected_q);
  assign OutData  = head_data;
  assign out_fire = OutValid && OutReady;

  // Expected count is seeded by the sync frame and advances on each delivery
  always_comb begin
    expected_d = expected_q;
    if (load_expected) begin
      expected_d = rx_tag;
    end else if (out_fire) begin
      expected_d = expected_q + FRAME_COUNT_WIDTH'(1);
    end
  end

  // Ack every stored or replayed frame one cycle after it arrives
  always_comb begin
    ack_valid_d = (rx_class == CLASS_STORE) || (rx_class == CLASS_DUP);
    ack_count_d = ack_valid_d ? rx_tag : ack_count_q;
  end

  // Saturating statistics for replays and frames too far ahead
  always_comb begin
    drop_d = drop_q;
    dup_d  = dup_q;
    if (rx_class == CLASS_DROP) begin
      drop_d = sat_inc16(drop_q);
    end
    if (rx_class == CLASS_DUP) begin
      dup_d = sat_inc16(dup_q);
    end
  end

  // Gap timer runs while frames wait behind an empty head slot
  always_comb begin
    gap_timer_d = gap_timer_q;
    if (!synced || head_valid || !any_valid) begin
      gap_timer_d = '0;
    end else if (gap_timer_q < GAP_LIMIT) begin
      gap_timer_d = gap_timer_q + GAP_W'(1);
    end
  end

  // Datapath registers; reset drops pending acks and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      expected_q  <= '0;
      ack_valid_q <= 1'b0;
      ack_count_q <= '0;
      drop_q      <= '0;
      dup_q       <= '0;
      gap_timer_q <= '0;
    end else begin
      expected_q  <= expected_d;
      ack_valid_q <= ack_valid_d;
      ack_count_q <= ack_count_d;
      drop_q      <= drop_d;
      dup_q       <= dup_d;
      gap_timer_q <= gap_timer_d;
    end
  end

  assign AckValid      = ack_valid_q;
  assign AckFrameCount = ack_count_q;
  assign ExpectedCount = expected_q;
  assign GapDetected   = gap_timer_q >= GAP_LIMIT;
  assign DropCount     = drop_q;
  assign DupCount      = dup_q;

endmodule

// File: tb/tb_rvvi_host_reorder_receiver.sv
// Bench for the RVVI host reorder receiver: directed scenarios plus a random
// phase, with a tag-keyed reference store predicting deliveries and acks and
// a negedge monitor draining the expectation queues.
module tb_rvvi_host_reorder_receiver;

  localparam int ENT = 3;
  localparam int W   = 792;
  localparam int FCW = 16;
  localparam int GAP = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           RxValid = 1'b0;
  logic [W-1:0]   RxData = '0;
  logic           OutReady = 1'b0;
  logic           OutValid;
  logic [W-1:0]   OutData;
  logic           AckValid;
  logic [FCW-1:0] AckFrameCount;
  logic [FCW-1:0] ExpectedCount;
  logic           GapDetected;
  logic [15:0]    DropCount;
  logic [15:0]    DupCount;

  int checks = 0;
  int fails  = 0;

  // Reference model: frames held keyed by tag, next tag to deliver, counters
  logic [W-1:0]   mStore [int];
  bit             mSynced = 0;
  logic [15:0]    mExp = '0;
  int             mDrop = 0;
  int             mDup  = 0;
  logic [W-1:0]   outQ [$];
  logic [15:0]    ackQ [$];
  logic           expOutValid = 1'b0;
  logic [W-1:0]   expOutData = '0;
  bit             monEn = 0;

  always #5 clk = ~clk;

  rvvi_host_reorder_receiver #(
    .Entries           (ENT),
    .WIDTH             (W),
    .FRAME_COUNT_WIDTH (FCW),
    .GAP_TIMEOUT       (GAP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .RxValid       (RxValid),
    .RxData        (RxData),
    .OutValid      (OutValid),
    .OutData       (OutData),
    .OutReady      (OutReady),
    .AckValid      (AckValid),
    .AckFrameCount (AckFrameCount),
    .ExpectedCount (ExpectedCount),
    .GapDetected   (GapDetected),
    .DropCount     (DropCount),
    .DupCount      (DupCount)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [63:0] act);
    checks++;
    fails++;
    $display("[TB] FAIL %s: got %h, expected nothing", name, act);
  endtask

  function automatic logic [W-1:0] makeFrame(input logic [15:0] tag);
    logic [W-1:0] f;
    f = '0;
    for (int i = 0; i < (W + 31) / 32; i++) begin
      f = {f[W-33:0], 32'($urandom)};
    end
    f[15:0] = tag;
    return f;
  endfunction

  // Advance the model by one clock edge with the inputs about to be applied
  task automatic modelStep(input logic rst, input logic rxv, input logic [W-1:0] frame, input logic rdy);
    logic [15:0] tag;
    logic [15:0] diff;
    logic        deliver;
    expOutValid = mSynced && mStore.exists(int'(mExp));
    expOutData  = expOutValid ? mStore[int'(mExp)] : '0;
    if (rst) begin
      mStore.delete();
      mSynced = 0;
      mExp    = '0;
      mDrop   = 0;
      mDup    = 0;
      return;
    end
    deliver = expOutValid && rdy;
    if (deliver) outQ.push_back(expOutData);
    if (rxv) begin
      tag = frame[15:0];
      if (!mSynced) begin
        mExp    = tag;
        mSynced = 1;
      end
      diff = tag - mExp;
      if (diff < 16'd8) begin
        ackQ.push_back(tag);
        if (mStore.exists(int'(tag))) begin
          if (mDup < 65535) mDup++;
        end else begin
          mStore[int'(tag)] = frame;
        end
      end else if (diff >= 16'h8000) begin
        ackQ.push_back(tag);
        if (mDup < 65535) mDup++;
      end else begin
        if (mDrop < 65535) mDrop++;
      end
    end
    if (deliver) begin
      mStore.delete(int'(mExp));
      mExp = mExp + 16'd1;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rxv, input logic [15:0] tag, input logic rdy);
    logic [W-1:0] frame;
    frame = makeFrame(tag);
    @(posedge clk);
    #2;
    reset    = rst;
    RxValid  = rxv;
    RxData   = frame;
    OutReady = rdy;
    modelStep(rst, rxv, frame, rdy);
    monEn = 1;
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, rdy);
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    idleCycles(1, 1'b0);
  endtask

  // Monitor: head visibility every cycle, deliveries and acks popped from the scoreboard
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("out_valid", OutValid, expOutValid);
      if (OutValid && expOutValid) checkOutput("out_data_head", OutData, expOutData);
      if (OutValid && OutReady) begin
        if (outQ.size() == 0) reportUnexpected("delivery_unexpected", OutData[63:0]);
        else checkOutput("delivery_data", OutData, outQ.pop_front());
      end
      if (AckValid) begin
        if (ackQ.size() == 0) reportUnexpected("ack_unexpected", 64'(AckFrameCount));
        else checkOutput("ack_frame_count", AckFrameCount, ackQ.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached before end of stimulus");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] tag;
    // Reset state
    resetDut();
    checkOutput("reset_expected", ExpectedCount, 16'd0);
    checkOutput("reset_out_valid", OutValid, 1'b0);
    checkOutput("reset_ack_valid", AckValid, 1'b0);
    checkOutput("reset_gap", GapDetected, 1'b0);
    checkOutput("reset_drop", DropCount, 16'd0);
    checkOutput("reset_dup", DupCount, 16'd0);

    // In-order stream
    applyStimulus(1'b0, 1'b1, 16'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd6, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd7, 1'b1);
    idleCycles(5, 1'b1);
    checkOutput("inorder_expected", ExpectedCount, 16'd8);

    // Reorder around a missing head
    resetDut();
    applyStimulus(1'b0, 1'b1, 16'd10, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd12, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd13, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd11, 1'b1);
    idleCycles(5, 1'b1);
    checkOutput("reorder_expected", ExpectedCount, 16'd14);
    checkOutput("reorder_gap", GapDetected, 1'b0);

    // Duplicate held frame and stale replay
    resetDut();
    applyStimulus(1'b0, 1'b1, 16'd19, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd21, 1'b1);
    idleCycles(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd21, 1'b1);
    idleCycles(2, 1'b1);
    checkOutput("dup_count_held", DupCount, 16'd1);
    applyStimulus(1'b0, 1'b1, 16'd18, 1'b1);
    idleCycles(2, 1'b1);
    checkOutput("dup_count_stale", DupCount, 16'd2);
    checkOutput("dup_expected", ExpectedCount, 16'd20);

    // Window edge: diff of 8 is dropped, diff of 7 is stored
    resetDut();
    applyStimulus(1'b0, 1'b1, 16'd29, 1'b1);
    idleCycles(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd38, 1'b1);
    idleCycles(2, 1'b1);
    checkOutput("window_drop", DropCount, 16'd1);
    applyStimulus(1'b0, 1'b1, 16'd37, 1'b1);
    idleCycles(2, 1'b1);
    checkOutput("window_drop_after_store", DropCount, 16'd1);
    checkOutput("window_expected", ExpectedCount, 16'd30);

    // Backpressure across the tag wrap
    resetDut();
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
    idleCycles(3, 1'b0);
    checkOutput("stall_out_valid", OutValid, 1'b1);
    checkOutput("stall_head_tag", OutData[15:0], 16'hFFFE);
    checkOutput("stall_expected", ExpectedCount, 16'hFFFE);
    idleCycles(6, 1'b1);
    checkOutput("wrap_expected", ExpectedCount, 16'h0001);

    // Gap timer rise and clear, then reset mid-stream
    resetDut();
    applyStimulus(1'b0, 1'b1, 16'd39, 1'b1);
    idleCycles(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd41, 1'b1);
    idleCycles(GAP - 1, 1'b1);
    checkOutput("gap_before_timeout", GapDetected, 1'b0);
    idleCycles(3, 1'b1);
    checkOutput("gap_after_timeout", GapDetected, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd40, 1'b1);
    idleCycles(3, 1'b1);
    checkOutput("gap_cleared", GapDetected, 1'b0);
    checkOutput("gap_expected", ExpectedCount, 16'd42);
    applyStimulus(1'b0, 1'b1, 16'd10, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd43, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'd99, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
    idleCycles(2, 1'b1);
    checkOutput("midreset_out_valid", OutValid, 1'b0);
    checkOutput("midreset_dup", DupCount, 16'd0);
    checkOutput("midreset_drop", DropCount, 16'd0);
    checkOutput("midreset_expected", ExpectedCount, 16'd0);
    applyStimulus(1'b0, 1'b1, 16'd200, 1'b1);
    idleCycles(3, 1'b1);
    checkOutput("resync_expected", ExpectedCount, 16'd201);

    // Random traffic around the window: reorders, replays, drops, stalls
    resetDut();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) tag = 16'($urandom);
      else tag = mExp + 16'($urandom_range(0, 19)) - 16'd5;
      applyStimulus(1'b0, ($urandom_range(0, 9) < 6), tag, ($urandom_range(0, 9) < 7));
    end
    idleCycles(20, 1'b1);
    checkOutput("random_drop", DropCount, 16'(mDrop));
    checkOutput("random_dup", DupCount, 16'(mDup));
    checkOutput("random_expected", ExpectedCount, mExp);
    checkOutput("delivery_queue_drained", 32'(outQ.size()), 32'd0);
    checkOutput("ack_queue_drained", 32'(ackQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rvvi_host_reorder_receiver.md
Name: rvvi_host_reorder_receiver

Overview:
- Host-side counterpart of the DUT-side RVVI active list; consumes RVVI frames arriving from the Ethernet receiver, possibly out of order, replayed or duplicated.
- Each frame is tagged with a frame count in its low FRAME_COUNT_WIDTH bits.
- Buffers frames in a window of 2^Entries slots and delivers them strictly in frame-count order to the downstream checker over a valid/ready interface.
- Emits one ack (HostInstrValid/HostFrameCount equivalent) per accepted or duplicate frame, so the DUT side can retire its active entries.

Parameters:
- Entries, 3: log2 of reorder window slots.
- WIDTH, 792: frame width in bits.
- FRAME_COUNT_WIDTH, 16: tag width; the tag is RxData[FRAME_COUNT_WIDTH-1:0]. Must be > Entries+1.
- GAP_TIMEOUT, 1024: cycles the head slot may stay empty while later slots are filled before GapDetected asserts.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- RxValid  input  1  frame present on RxData this cycle. No backpressure is provided.
- RxData  input  WIDTH  frame; low FRAME_COUNT_WIDTH bits are the tag.
- OutValid  output  1  in-order frame available.
- OutData  output  WIDTH  head frame.
- OutReady  input  1  downstream accepts OutData.
- AckValid  output  1  one-cycle ack pulse.
- AckFrameCount  output  FRAME_COUNT_WIDTH  tag being acked.
- ExpectedCount  output  FRAME_COUNT_WIDTH  next tag to deliver.
- GapDetected  output  1  head missing longer than GAP_TIMEOUT.
- DropCount  output  16  saturating count of out-of-window drops.
- DupCount  output  16  saturating count of duplicates.

Behaviour:
- Reset:
  - State is UNSYNCED; all slot valid bits clear; ExpectedCount=0.
  - OutValid=0, AckValid=0, GapDetected=0, DropCount=0, DupCount=0.
- FSM states:
  - UNSYNCED: the first RxValid loads ExpectedCount with its tag, then the frame is classified as in-window with diff=0 and stored. Transition to SYNCED.
  - SYNCED: stays there until reset. There is no other exit.
- Classification in SYNCED: diff = tag - ExpectedCount, computed modulo 2^FRAME_COUNT_WIDTH.
  - diff < 2^Entries (in window):
    - If slot[tag[Entries-1:0]] is empty: write the frame and tag, set valid, ack.
    - If the slot is valid with an equal tag: duplicate; no write, ack, DupCount++.
  - diff >= 2^(FRAME_COUNT_WIDTH-1) (behind, already delivered): stale replay; discard, ack, DupCount++.
  - Otherwise (ahead beyond window): discard, no ack, DropCount++.
- Ack timing:
  - AckValid/AckFrameCount are registered and appear the cycle after RxValid.
  - At most one ack per cycle, since there is at most one Rx frame per cycle.
- Delivery:
  - OutValid = slot[ExpectedCount[Entries-1:0]].valid, and the stored tag equals ExpectedCount.
  - OutData is that slot's data.
  - A stored frame can first appear on OutValid the cycle after its RxValid; there is no same-cycle bypass.
  - On OutValid & OutReady: clear the slot and increment ExpectedCount (wraps modulo 2^FRAME_COUNT_WIDTH).
  - OutData must hold stable while OutValid & ~OutReady.
- Simultaneous events:
  - Rx write and drain in the same cycle are always to different slots. A tag equal to ExpectedCount while its slot is valid is a duplicate; a tag aliasing that slot with diff = 2^Entries is out of window.
  - Classification uses the pre-increment ExpectedCount.
- Counters:
  - DropCount and DupCount saturate at 0xFFFF.
- Gap timer:
  - Counts while SYNCED, the head slot is empty, and any slot is valid.
  - Clears when the head slot fills or all slots are empty.
  - GapDetected = timer >= GAP_TIMEOUT. It is level, not sticky.
- Wrap-around:
  - Tag 0xFFFF followed by tag 0x0000 is handled as consecutive.
- Reset mid-operation:
  - All buffered frames are discarded, any pending ack is cancelled, and the FSM returns to UNSYNCED.

Decomposition:
- rvvi_pkg holds:
  - the state typedef {STATE_UNSYNCED, STATE_SYNCED};
  - a default FRAME_COUNT_WIDTH localparam, shared with the DUT-side active list.
- Sub-module rvvi_reorder_slots holds the storage:
  - 2^Entries x WIDTH data array, tag array and valid bits;
  - one write port and one clear port, with combinational read at the head index.
- Classification, FSM, ack register, counters and gap timer live in the top module.

Test Plan:
- In order: reset; Rx tags 5,6,7 on consecutive cycles with OutReady=1 -> OutData tags 5,6,7 starting the cycle after tag 5 arrives; AckFrameCount 5,6,7; ExpectedCount=8.
- Reorder: sync at tag 10; then send tags 12,13,11 with OutReady=1 -> OutValid stays 0 until 11 arrives, then delivers 11,12,13 on consecutive cycles; three acks in arrival order 12,13,11; GapDetected=0.
- Duplicate and stale: Expected=20 with slot for 21 holding 21; send 21 -> ack 21, DupCount=1, no write; send 18 -> ack 18, DupCount=2, not delivered.
- Out of window: Entries=3, Expected=30; send tag 38 -> no AckValid, DropCount=1; send tag 37 -> stored and acked.
- Backpressure and wrap: sync at 0xFFFE, send 0xFFFE, 0xFFFF, 0x0000 with OutReady=0 -> OutData holds 0xFFFE; raise OutReady -> delivers all three; ExpectedCount=0x0001.
- Gap and reset: Expected=40, send 41 only -> GapDetected rises GAP_TIMEOUT cycles later; send 40 -> GapDetected clears; assert reset mid-stream -> OutValid=0, counters 0, next frame resyncs ExpectedCount.
